// File: rtl/bm_solver_param_pkg.sv
// Shared BCH decoder constants, solver state encoding and width helpers.
package bch_pkg;

  localparam int          BCH_M         = 16;
  localparam int          BCH_T         = 12;
  localparam logic [16:0] BCH_PRIM_POLY = 17'h1100B;

  typedef enum logic [1:0] {IDLE, ITER, DONE} bm_state_e;

  // Width able to hold any locator degree / iteration index up to 2T.
  function automatic int deg_w(input int t);
    return $clog2(2 * t + 1);
  endfunction

endpackage

// File: rtl/bm_solver_param_if.sv
// Syndrome-in / locator-out handshake bus between syndrome calc, BM solver and Chien search.
interface bm_solver_param_if
  import bch_pkg::*;
#(
  parameter int M = BCH_M,
  parameter int T = BCH_T
);
  localparam int DW = deg_w(T);

  logic                 syn_valid;
  logic                 syn_ready;
  logic [2*T*M-1:0]     syn_in;
  logic                 lam_valid;
  logic                 lam_ready;
  logic [(T+1)*M-1:0]   lam_out;
  logic [DW-1:0]        lam_deg;
  logic                 uncorrectable;

  modport slave (
    input  syn_valid, syn_in, lam_ready,
    output syn_ready, lam_valid, lam_out, lam_deg, uncorrectable
  );

  modport master (
    output syn_valid, syn_in, lam_ready,
    input  syn_ready, lam_valid, lam_out, lam_deg, uncorrectable
  );
endinterface

// File: rtl/bm_solver_param_gf_mult.sv
// Combinational GF(2^M) multiplier, shift-and-add with reduction by PRIM_POLY.
module gf_mult #(
  parameter int         M         = 16,
  parameter logic [M:0] PRIM_POLY = 17'h1100B
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] p
);
  logic [M-1:0] acc;
  logic [M-1:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ sh;
      // multiply running term by x and fold the overflow back in
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PRIM_POLY[M-1:0] : '0);
    end
    p = acc;
  end
endmodule

// File: rtl/bm_solver_param.sv
// Inversionless Berlekamp-Massey key-equation solver: 2T syndromes in,
// scaled error-locator, degree L and uncorrectable flag out.
module bm_solver_param
  import bch_pkg::*;
#(
  parameter int         M           = BCH_M,
  parameter int         T           = BCH_T,          // T >= 2
  parameter logic [M:0] PRIM_POLY   = BCH_PRIM_POLY,
  parameter bit         BINARY_MODE = 1'b0
) (
  input  logic             CLK,
  input  logic             RST_N,
  bm_solver_param_if.slave bus
);
  localparam int                DW       = deg_w(T);
  localparam int                STEP     = BINARY_MODE ? 2 : 1;
  localparam logic [DW-1:0]     LAST_R   = DW'(2 * T - STEP);
  localparam logic [T:0][M-1:0] ONE_POLY = ((T + 1) * M)'(1);

  bm_state_e             state_q, state_d;
  logic [2*T-1:0][M-1:0] syn_q, syn_d;
  logic [T:0][M-1:0]     lam_q, lam_d;
  logic [T:0][M-1:0]     b_q, b_d;
  logic [M-1:0]          gam_q, gam_d;
  logic [DW-1:0]         l_q, l_d;
  logic [DW-1:0]         r_q, r_d;
  logic                  trunc_q, trunc_d;

  logic [T:0][M-1:0]     s_sel, d_term, g_lam, d_b, lam_nxt;
  logic [M-1:0]          delta;
  logic                  swap;
  logic [DW-1:0]         hi_idx;
  logic                  done;

  // Per coefficient: discrepancy term, gamma*lambda and delta*B.
  for (genvar i = 0; i <= T; i++) begin : g_lane
    gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_dlt (.a(lam_q[i]), .b(s_sel[i]), .p(d_term[i]));
    gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_gam (.a(gam_q),    .b(lam_q[i]), .p(g_lam[i]));
    gf_mult #(.M(M), .PRIM_POLY(PRIM_POLY)) u_db  (.a(delta),    .b(b_q[i]),   .p(d_b[i]));
  end

  // lambda_i pairs with S_(r+1-i); out-of-range syndromes read as zero.
  always_comb begin
    s_sel = '0;
    for (int i = 0; i <= T; i++)
      for (int k = 1; k <= 2 * T; k++)
        if (int'(r_q) + 1 - i == k) s_sel[i] = syn_q[k-1];
  end

  always_comb begin
    delta = '0;
    for (int i = 0; i <= T; i++) delta = delta ^ d_term[i];
  end

  always_comb begin
    lam_nxt = g_lam;
    for (int i = 1; i <= T; i++) lam_nxt[i] = lam_nxt[i] ^ d_b[i-1];
  end

  assign swap = (delta != '0) && ({l_q, 1'b0} <= {1'b0, r_q});

  always_comb begin
    state_d = state_q;
    syn_d   = syn_q;
    lam_d   = lam_q;
    b_d     = b_q;
    gam_d   = gam_q;
    l_d     = l_q;
    r_d     = r_q;
    trunc_d = trunc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.syn_valid) begin
          syn_d   = bus.syn_in;
          lam_d   = ONE_POLY;
          b_d     = ONE_POLY;
          gam_d   = M'(1);
          l_d     = '0;
          r_d     = '0;
          trunc_d = 1'b0;
          state_d = ITER;
        end
      end
      ITER: begin
        lam_d = lam_nxt;
        // delta*B_T would land on x^(T+1): lost, so remember it
        trunc_d = trunc_q | (d_b[T] != '0);
        if (swap) begin
          if (BINARY_MODE) b_d = {lam_q[T-1:0], {M{1'b0}}};
          else             b_d = lam_q;
          l_d   = r_q + DW'(1) - l_q;
          gam_d = delta;
        end else begin
          if (BINARY_MODE) b_d = {b_q[T-2:0], {(2*M){1'b0}}};
          else             b_d = {b_q[T-1:0], {M{1'b0}}};
        end
        r_d = r_q + DW'(STEP);
        if (r_q == LAST_R) state_d = DONE;
      end
      DONE: begin
        if (bus.lam_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      syn_q   <= '0;
      lam_q   <= ONE_POLY;
      b_q     <= ONE_POLY;
      gam_q   <= M'(1);
      l_q     <= '0;
      r_q     <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      syn_q   <= syn_d;
      lam_q   <= lam_d;
      b_q     <= b_d;
      gam_q   <= gam_d;
      l_q     <= l_d;
      r_q     <= r_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    hi_idx = '0;
    for (int i = 0; i <= T; i++)
      if (lam_q[i] != '0) hi_idx = DW'(i);
  end

  // Outputs are masked outside DONE so a partial result never leaks.
  assign done              = (state_q == DONE);
  assign bus.syn_ready     = (state_q == IDLE);
  assign bus.lam_valid     = done;
  assign bus.lam_out       = done ? lam_q : '0;
  assign bus.lam_deg       = done ? l_q : '0;
  assign bus.uncorrectable = done && ((l_q > DW'(T)) || (hi_idx != l_q) || trunc_q);

endmodule

// File: tb/tb_bm_solver_param.sv
// Directed + randomized bench for bm_solver_param: small GF(16) instances and the default GF(2^16), T=12 instance.
module tb_bm_solver_param;
  import bch_pkg::*;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  bm_solver_param_if #(.M(4),  .T(2))  b0 ();
  bm_solver_param_if #(.M(4),  .T(2))  b1 ();
  bm_solver_param_if #(.M(16), .T(12)) b2 ();

  bm_solver_param #(.M(4), .T(2), .PRIM_POLY(5'h13), .BINARY_MODE(1'b0)) u0 (.CLK(CLK), .RST_N(RST_N), .bus(b0));
  bm_solver_param #(.M(4), .T(2), .PRIM_POLY(5'h13), .BINARY_MODE(1'b1)) u1 (.CLK(CLK), .RST_N(RST_N), .bus(b1));
  bm_solver_param #(.M(16), .T(12), .PRIM_POLY(17'h1100B), .BINARY_MODE(1'b0)) u2 (.CLK(CLK), .RST_N(RST_N), .bus(b2));

  typedef struct {
    logic [207:0] lam;
    logic [4:0]   deg;
    logic         unc;
    int           lat;
    bit           chk_lam;
    bit           chk_du;
  } exp_t;

  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [207:0] obs, input logic [207:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input logic [207:0] lam, input logic [4:0] deg, input logic unc,
                           input int cyc, input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, " latency"}, cyc, e.lat);
    if (e.chk_lam) chk({tag, " lam_out"}, lam, e.lam);
    if (e.chk_du) begin
      chk({tag, " lam_deg"}, deg, e.deg);
      chk({tag, " uncorrectable"}, unc, e.unc);
    end
  endtask

  // GF(2^16) reference arithmetic, x^16+x^12+x^3+x+1
  function automatic logic [15:0] gmul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] p = '0;
    logic [15:0] s = a;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) p = p ^ s;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000);
    end
    return p;
  endfunction

  function automatic logic [15:0] apow(input int e);
    logic [15:0] r = 16'h0001;
    logic [15:0] base = 16'h0002;
    int x = e % 65535;
    while (x > 0) begin
      if (x[0]) r = gmul(r, base);
      base = gmul(base, base);
      x = x >> 1;
    end
    return r;
  endfunction

  task automatic run_small(input bit bin, input logic [15:0] syn, input logic [11:0] exp_lam,
                           input logic [2:0] exp_deg, input logic exp_unc, input int lat,
                           input int hold, input string tag);
    exp_t e;
    int cyc;
    e.lam = 208'(exp_lam); e.deg = 5'(exp_deg); e.unc = exp_unc; e.lat = lat;
    e.chk_lam = 1'b1; e.chk_du = 1'b1;
    sb.push_back(e);
    @(negedge CLK);
    if (bin) begin b1.syn_in = syn; b1.syn_valid = 1'b1; end
    else     begin b0.syn_in = syn; b0.syn_valid = 1'b1; end
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
      if (cyc == 1) begin b0.syn_valid = 1'b0; b1.syn_valid = 1'b0; end
    end while (!(bin ? b1.lam_valid : b0.lam_valid) && cyc < 60);
    if (bin) check_out(208'(b1.lam_out), 5'(b1.lam_deg), b1.uncorrectable, cyc, tag);
    else     check_out(208'(b0.lam_out), 5'(b0.lam_deg), b0.uncorrectable, cyc, tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      b0.syn_valid = h[0];
      b0.syn_in    = 16'h1234;
      @(posedge CLK); #1;
      chk({tag, " hold lam_out"}, 208'(b0.lam_out), 208'(exp_lam));
      chk({tag, " hold lam_valid"}, b0.lam_valid, 1);
      chk({tag, " hold syn_ready"}, b0.syn_ready, 0);
    end
    @(negedge CLK);
    b0.syn_valid = 1'b0;
    if (bin) b1.lam_ready = 1'b1; else b0.lam_ready = 1'b1;
    @(posedge CLK); #1;
    b0.lam_ready = 1'b0; b1.lam_ready = 1'b0;
    chk({tag, " release syn_ready"}, bin ? b1.syn_ready : b0.syn_ready, 1);
    chk({tag, " release lam_valid"}, bin ? b1.lam_valid : b0.lam_valid, 0);
  endtask

  task automatic run_big(input int nerr, input string tag);
    int pos[$];
    int p;
    bit dup;
    logic [383:0] syn;
    logic [15:0] s, v, xr;
    logic [207:0] lo;
    exp_t e;
    int cyc, roots;
    while (pos.size() < nerr) begin
      p = int'($urandom_range(0, 65534));
      dup = 1'b0;
      foreach (pos[j]) if (pos[j] == p) dup = 1'b1;
      if (!dup) pos.push_back(p);
    end
    for (int k = 1; k <= 24; k++) begin
      s = '0;
      foreach (pos[j]) s = s ^ apow(k * pos[j]);
      syn[k*16-1 -: 16] = s;
    end
    e.lam = '0; e.deg = 5'(nerr); e.unc = 1'b0; e.lat = 25;
    e.chk_lam = 1'b0; e.chk_du = (nerr <= 12);
    sb.push_back(e);
    @(negedge CLK);
    b2.syn_in = syn; b2.syn_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
      if (cyc == 1) b2.syn_valid = 1'b0;
    end while (!b2.lam_valid && cyc < 100);
    check_out(b2.lam_out, b2.lam_deg, b2.uncorrectable, cyc, tag);
    lo = b2.lam_out;
    roots = 0;
    foreach (pos[j]) begin
      xr = apow(65535 - pos[j]);
      v = '0;
      for (int i = 12; i >= 0; i--) v = gmul(v, xr) ^ lo[i*16 +: 16];
      if (v == '0) roots++;
    end
    if (nerr <= 12) chk({tag, " chien roots"}, roots, nerr);
    else chk({tag, " overload detected"}, (b2.uncorrectable || roots < nerr), 1);
    @(negedge CLK);
    b2.lam_ready = 1'b1;
    @(posedge CLK); #1;
    b2.lam_ready = 1'b0;
    chk({tag, " release syn_ready"}, b2.syn_ready, 1);
  endtask

  initial begin
    b0.syn_valid = 1'b0; b0.syn_in = '0; b0.lam_ready = 1'b0;
    b1.syn_valid = 1'b0; b1.syn_in = '0; b1.lam_ready = 1'b0;
    b2.syn_valid = 1'b0; b2.syn_in = '0; b2.lam_ready = 1'b0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset syn_ready", b0.syn_ready, 1);
    chk("reset lam_valid", b0.lam_valid, 0);
    chk("reset lam_out", 208'(b0.lam_out), 0);
    chk("reset lam_deg", 208'(b0.lam_deg), 0);
    chk("reset uncorrectable", b0.uncorrectable, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    run_small(1'b0, 16'h0000, 12'h001, 3'd0, 1'b0, 5, 0, "zero");
    run_small(1'b0, 16'hFAC8, 12'h0FA, 3'd1, 1'b0, 5, 0, "single");
    run_small(1'b0, 16'h2953, 12'h8C4, 3'd2, 1'b0, 5, 0, "double");
    run_small(1'b1, 16'hFAC8, 12'h0C8, 3'd1, 1'b0, 3, 0, "single_bin");
    run_small(1'b1, 16'h2953, 12'h653, 3'd2, 1'b0, 3, 0, "double_bin");
    run_small(1'b1, 16'h0000, 12'h001, 3'd0, 1'b0, 3, 0, "zero_bin");
    run_small(1'b0, 16'h0100, 12'h001, 3'd3, 1'b1, 5, 0, "over_t");
    run_small(1'b0, 16'hFAC8, 12'h0FA, 3'd1, 1'b0, 5, 10, "backpressure");

    // asynchronous reset while u0 is at r=1
    @(negedge CLK);
    b0.syn_in = 16'hFAC8; b0.syn_valid = 1'b1;
    @(posedge CLK); #1;
    b0.syn_valid = 1'b0;
    @(posedge CLK); #1;
    chk("iter syn_ready", b0.syn_ready, 0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst syn_ready", b0.syn_ready, 1);
    chk("midrst lam_valid", b0.lam_valid, 0);
    chk("midrst lam_out", 208'(b0.lam_out), 0);
    chk("midrst lam_deg", 208'(b0.lam_deg), 0);
    chk("midrst uncorrectable", b0.uncorrectable, 0);
    repeat (2) @(negedge CLK);
    #2;
    RST_N = 1'b1;
    run_small(1'b0, 16'hFAC8, 12'h0FA, 3'd1, 1'b0, 5, 0, "post_rst");
    run_small(1'b0, 16'h2953, 12'h8C4, 3'd2, 1'b0, 5, 0, "post_rst2");

    run_big(1, "rand1");
    run_big(2, "rand2");
    run_big(5, "rand5");
    run_big(int'($urandom_range(3, 11)), "randN");
    run_big(12, "rand12");
    run_big(14, "rand14");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
